// File: rtl/g18_pkg.sv
// Shared types and widths for the G18 BPI flash read controller.
// Used by g18_flash_ctrl.
package g18_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RESP
  } g18_state_t;

  localparam int G18_ADR_W = 23;
  localparam int G18_DAT_W = 16;

endpackage

// File: rtl/g18_flash_ctrl.sv
// Read-only Wishbone slave fetching 32-bit words as two 16-bit flash reads.
// Define G18_CACHE_EN to add a one-entry read cache.
module g18_flash_ctrl
  import g18_pkg::*;
#(
  parameter int ADR_W       = G18_ADR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [ADR_W-1:0]     g18_adr_o,
  output logic                 g18_wen_o,
  inout  wire  [G18_DAT_W-1:0] g18_dat_io
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  g18_state_t state_q, state_d;

  logic [CNT_W-1:0]     cnt_q;
  logic [G18_DAT_W-1:0] hi_q;
  logic                 err_q;
  logic [ADR_W-2:0]     req_tag;
  logic                 req;
  logic                 cnt_zero;
  logic                 hit;
  logic [31:0]          hit_dat;
  logic                 unused;

  assign g18_dat_io = {G18_DAT_W{1'bz}};

  assign unused = ^{wb_dat_i, wb_sel_i,
                    wb_adr_i[31:ADR_W+1],
                    wb_adr_i[1:0]};

  assign req_tag  = wb_adr_i[ADR_W:2];
  assign cnt_zero = (cnt_q == '0);

  // A held strobe must not retrigger while the last response is visible
  assign req = wb_cyc_i & wb_stb_i
             & ~wb_ack_o & ~wb_err_o;

`ifdef G18_CACHE_EN
  logic             c_vld;
  logic [ADR_W-2:0] c_tag;
  logic [31:0]      c_dat;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      c_vld <= 1'b0;
      c_tag <= '0;
      c_dat <= '0;
    end else if (state_q == RD_LO &&
                 wb_cyc_i && cnt_zero) begin
      c_vld <= 1'b1;
      c_tag <= g18_adr_o[ADR_W-1:1];
      c_dat <= {hi_q, g18_dat_io};
    end
  end

  assign hit     = c_vld & (c_tag == req_tag);
  assign hit_dat = c_dat;
`else
  assign hit     = 1'b0;
  assign hit_dat = '0;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (wb_we_i || hit) state_d = RESP;
          else                state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (!wb_cyc_i)     state_d = IDLE;
        else if (cnt_zero) state_d = RD_LO;
      end
      RD_LO: begin
        if (!wb_cyc_i)     state_d = IDLE;
        else if (cnt_zero) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      g18_adr_o <= '0;
      g18_wen_o <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            err_q <= wb_we_i;
            if (!wb_we_i) begin
              if (hit) begin
                wb_dat_o <= hit_dat;
              end else begin
                g18_adr_o <= {req_tag, 1'b0};
                g18_wen_o <= 1'b1;
                cnt_q     <= CNT_INIT;
              end
            end
          end
        end
        RD_HI: begin
          if (!wb_cyc_i) begin
            g18_wen_o <= 1'b0;
          end else if (cnt_zero) begin
            hi_q         <= g18_dat_io;
            g18_adr_o[0] <= 1'b1;
            cnt_q        <= CNT_INIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RD_LO: begin
          if (!wb_cyc_i) begin
            g18_wen_o <= 1'b0;
          end else if (cnt_zero) begin
            wb_dat_o  <= {hi_q, g18_dat_io};
            g18_wen_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          wb_ack_o <= ~err_q;
          wb_err_o <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule
